// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared types, encodings and access-legality helpers for the request sequencer
package mem_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_RD = 3'd2,
        WAIT_WR = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] WT_NONE = 2'b00;
    localparam logic [1:0] WT_BYTE = 2'b01;
    localparam logic [1:0] WT_HALF = 2'b10;
    localparam logic [1:0] WT_WORD = 2'b11;

    localparam logic [2:0] RT_NONE       = 3'b000;
    localparam int         RT_SIGNED_BIT = 2;

    // Misalignment, illegal size, non-byte I/O, or a signed load from a UART register.
    function automatic logic access_illegal(
        input logic [1:0] size,
        input logic [1:0] addr_lo,
        input logic       is_io,
        input logic       is_uart,
        input logic       write,
        input logic       is_unsigned
    );
        logic misaligned;
        logic io_bad;
        case (size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = addr_lo[0];
            SIZE_WORD: misaligned = |addr_lo;
            default:   misaligned = 1'b1;
        endcase
        io_bad = is_io && ((size != SIZE_BYTE) || (!write && !is_unsigned && is_uart));
        return misaligned || io_bad;
    endfunction

    function automatic logic [1:0] write_type_of(input logic [1:0] size);
        return size + 2'd1;
    endfunction

    // I/O registers are always read as an unsigned byte; words carry the signed flag by convention of the I/O block.
    function automatic logic [2:0] read_type_of(
        input logic [1:0] size,
        input logic       is_unsigned,
        input logic       is_io
    );
        logic [2:0] rt;
        if (is_io) begin
            rt = {1'b0, WT_BYTE};
        end else if (size == SIZE_WORD) begin
            rt = {1'b1, WT_WORD};
        end else begin
            rt = {1'b0, write_type_of(size)};
            rt[RT_SIGNED_BIT] = ~is_unsigned;
        end
        return rt;
    endfunction

endpackage

// File: rtl/mem_request_sequencer_if.sv
// rtl/mem_request_sequencer_if.sv - core request/response and I/O-block bus bundle
interface mem_request_sequencer_if #(
    parameter int ADDRESS_BITWIDTH = 32,
    parameter int DATA_WIDTH       = 32
) ();
    logic                        req_valid;
    logic                        req_ready;
    logic                        req_write;
    logic [1:0]                  req_size;
    logic                        req_unsigned;
    logic [ADDRESS_BITWIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]       req_wdata;
    logic                        resp_valid;
    logic [DATA_WIDTH-1:0]       resp_rdata;
    logic                        resp_err;
    logic [ADDRESS_BITWIDTH-1:0] mem_address;
    logic [1:0]                  mem_write_type;
    logic [2:0]                  mem_read_type;
    logic [DATA_WIDTH-1:0]       mem_data_in;
    logic [DATA_WIDTH-1:0]       mem_data_out;
    logic                        mem_data_out_ready;
    logic                        mem_busy;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_data_out, mem_data_out_ready, mem_busy,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_write_type, mem_read_type, mem_data_in
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_data_out, mem_data_out_ready, mem_busy,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_write_type, mem_read_type, mem_data_in
    );
endinterface

// File: rtl/mem_request_sequencer.sv
// rtl/mem_request_sequencer.sv - single-outstanding load/store to level-held I/O-block request sequencer
module mem_request_sequencer
    import mem_seq_pkg::*;
#(
    parameter int                            ADDRESS_BITWIDTH = 32,
    parameter int                            DATA_WIDTH       = 32,
    parameter logic [ADDRESS_BITWIDTH-1:0]   TOP_ADDRESS      = '1,
    parameter logic [ADDRESS_BITWIDTH-1:0]   ADDRESS_LEDS     = TOP_ADDRESS,
    parameter logic [ADDRESS_BITWIDTH-1:0]   ADDRESS_UART_OUT = TOP_ADDRESS - ADDRESS_BITWIDTH'(1),
    parameter logic [ADDRESS_BITWIDTH-1:0]   ADDRESS_UART_IN  = TOP_ADDRESS - ADDRESS_BITWIDTH'(2),
    parameter int                            TIMEOUT_CYCLES   = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_request_sequencer_if.slave bus
);

    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                      r_state;
    logic                        r_req_ready;
    logic                        r_write;
    logic [1:0]                  r_size;
    logic                        r_unsigned;
    logic [1:0]                  r_addr_lo;
    logic                        r_is_io;
    logic [CNT_W-1:0]            r_cnt;
    logic                        r_resp_valid;
    logic                        r_resp_err;
    logic [DATA_WIDTH-1:0]       r_resp_rdata;
    logic [ADDRESS_BITWIDTH-1:0] r_mem_address;
    logic [1:0]                  r_mem_write_type;
    logic [2:0]                  r_mem_read_type;
    logic [DATA_WIDTH-1:0]       r_mem_data_in;

    logic                        w_accept;
    logic                        w_req_uart;
    logic                        w_req_io;
    logic                        w_req_err;
    logic [CNT_W-1:0]            w_cnt_next;
    logic                        w_waiting;
    logic                        w_io_done;
    logic                        w_rd_done;
    logic                        w_wr_done;
    logic                        w_ok;
    logic                        w_fail;
    logic [DATA_WIDTH-1:0]       w_lane;
    logic [DATA_WIDTH-1:0]       w_load_data;
    logic [DATA_WIDTH-1:0]       w_resp_data;

    assign w_accept   = bus.req_valid && r_req_ready;
    assign w_req_uart = (bus.req_addr == ADDRESS_UART_OUT) || (bus.req_addr == ADDRESS_UART_IN);
    assign w_req_io   = w_req_uart || (bus.req_addr == ADDRESS_LEDS);
    assign w_req_err  = access_illegal(bus.req_size, bus.req_addr[1:0], w_req_io, w_req_uart,
                                       bus.req_write, bus.req_unsigned);

    assign w_cnt_next = r_cnt + CNT_W'(1);
    assign w_waiting  = (r_state == ISSUE) || (r_state == WAIT_RD) || (r_state == WAIT_WR);
    assign w_io_done  = (r_state == ISSUE) && r_is_io;
    assign w_rd_done  = (r_state == WAIT_RD) && bus.mem_data_out_ready && !bus.mem_busy;
    assign w_wr_done  = (r_state == WAIT_WR) && !bus.mem_busy;
    assign w_ok       = w_io_done || w_rd_done || w_wr_done;
    // A completion on the same edge as the deadline still wins over the timeout.
    assign w_fail     = w_waiting && !w_ok && (w_cnt_next >= TMO_LAST);

    // RAM returns the whole word; pick the addressed lane and extend it.
    assign w_lane = bus.mem_data_out >> {r_addr_lo, 3'b000};

    // Sign/zero-extend the selected lane according to the captured size.
    always_comb begin
        w_load_data = w_lane;
        case (r_size)
            SIZE_BYTE: w_load_data = {{(DATA_WIDTH-8){~r_unsigned & w_lane[7]}}, w_lane[7:0]};
            SIZE_HALF: w_load_data = {{(DATA_WIDTH-16){~r_unsigned & w_lane[15]}}, w_lane[15:0]};
            default:   w_load_data = w_lane;
        endcase
    end

    // Select the value returned on completion: RAM lane data, raw I/O byte, or zero.
    always_comb begin
        w_resp_data = '0;
        if (w_rd_done) begin
            w_resp_data = w_load_data;
        end else if (w_io_done && !r_write) begin
            w_resp_data = {{(DATA_WIDTH-8){1'b0}}, bus.mem_data_out[7:0]};
        end
    end

    // Request FSM with all bus-facing outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_req_ready      <= 1'b1;
            r_write          <= 1'b0;
            r_size           <= SIZE_BYTE;
            r_unsigned       <= 1'b0;
            r_addr_lo        <= 2'b00;
            r_is_io          <= 1'b0;
            r_cnt            <= '0;
            r_resp_valid     <= 1'b0;
            r_resp_err       <= 1'b0;
            r_resp_rdata     <= '0;
            r_mem_address    <= '0;
            r_mem_write_type <= WT_NONE;
            r_mem_read_type  <= RT_NONE;
            r_mem_data_in    <= '0;
        end else if (w_ok || w_fail) begin
            r_state          <= RESP;
            r_resp_valid     <= 1'b1;
            r_resp_err       <= w_fail;
            r_resp_rdata     <= w_fail ? '0 : w_resp_data;
            r_mem_address    <= '0;
            r_mem_write_type <= WT_NONE;
            r_mem_read_type  <= RT_NONE;
            r_mem_data_in    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_write     <= bus.req_write;
                        r_size      <= bus.req_size;
                        r_unsigned  <= bus.req_unsigned;
                        r_addr_lo   <= bus.req_addr[1:0];
                        r_is_io     <= w_req_io;
                        r_cnt       <= '0;
                        if (w_req_err) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state         <= ISSUE;
                            r_mem_address   <= bus.req_addr;
                            r_mem_data_in   <= bus.req_write ? bus.req_wdata : '0;
                            // I/O stores fire in ISSUE; RAM stores wait for the cache to be idle.
                            r_mem_write_type <= (bus.req_write && w_req_io) ?
                                                write_type_of(bus.req_size) : WT_NONE;
                            r_mem_read_type  <= bus.req_write ? RT_NONE :
                                                read_type_of(bus.req_size, bus.req_unsigned, w_req_io);
                        end
                    end
                end
                ISSUE: begin
                    r_cnt <= w_cnt_next;
                    if (!bus.mem_busy) begin
                        if (r_write) begin
                            r_mem_write_type <= write_type_of(r_size);
                            r_state          <= WAIT_WR;
                        end else begin
                            r_state <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    r_cnt <= w_cnt_next;
                end
                WAIT_WR: begin
                    r_cnt            <= w_cnt_next;
                    r_mem_write_type <= WT_NONE;
                end
                RESP: begin
                    r_state      <= IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready      = r_req_ready;
    assign bus.resp_valid     = r_resp_valid;
    assign bus.resp_err       = r_resp_err;
    assign bus.resp_rdata     = r_resp_rdata;
    assign bus.mem_address    = r_mem_address;
    assign bus.mem_write_type = r_mem_write_type;
    assign bus.mem_read_type  = r_mem_read_type;
    assign bus.mem_data_in    = r_mem_data_in;

endmodule

// File: tb/tb_mem_request_sequencer.sv
// tb/tb_mem_request_sequencer.sv - scoreboard bench for mem_request_sequencer
module tb_mem_request_sequencer;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    logic prev_wt_nz;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        logic [2:0]  rt;
    } ld_vec_t;

    mem_request_sequencer_if #(.ADDRESS_BITWIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_request_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_write_type != 2'b00) chk("wt_single_cycle", {31'b0, prev_wt_nz}, 32'd0);
            prev_wt_nz = (bus.mem_write_type != 2'b00);
            if (bus.resp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp actual=1 required=0 cyc=%0d", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_rdata", bus.resp_rdata, e.rdata);
                    chk("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
                    chk("resp_cycle", cyc, e.cyc);
                end
            end
        end else begin
            prev_wt_nz = 1'b0;
        end
    end

    // Issues one request; returns 1 time unit after the accepting edge.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_resp, input logic [31:0] exp_rd,
                         input logic exp_err, input int lat);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_ready_wait actual=0 required=1");
        end
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        if (exp_resp) begin
            e.rdata = exp_rd;
            e.err   = exp_err;
            e.cyc   = cyc + lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_addr     = ~addr;
        bus.req_wdata    = $urandom;
        bus.req_size     = 2'b11;
        bus.req_unsigned = ~uns;
        bus.req_write    = ~wr;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
        chk({tag, "_resp_valid"}, {31'b0, bus.resp_valid}, 32'd0);
        chk({tag, "_resp_err"}, {31'b0, bus.resp_err}, 32'd0);
        chk({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
        chk({tag, "_mem_address"}, bus.mem_address, 32'd0);
        chk({tag, "_mem_wt"}, {30'b0, bus.mem_write_type}, 32'd0);
        chk({tag, "_mem_rt"}, {29'b0, bus.mem_read_type}, 32'd0);
        chk({tag, "_mem_data_in"}, bus.mem_data_in, 32'd0);
    endtask

    initial begin
        ld_vec_t vecs[5];
        int bad;
        int g;
        vecs = '{
            '{2'b10, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b111},
            '{2'b01, 1'b1, 32'h0000_0002, 32'hBEEF_1234, 32'h0000_BEEF, 3'b010},
            '{2'b01, 1'b0, 32'h0000_0002, 32'hBEEF_1234, 32'hFFFF_BEEF, 3'b110},
            '{2'b01, 1'b0, 32'h0000_0010, 32'h0001_7FFF, 32'h0000_7FFF, 3'b110},
            '{2'b00, 1'b1, 32'h0000_0001, 32'h0000_A500, 32'h0000_00A5, 3'b001}
        };
        checks = 0;
        failures = 0;
        prev_wt_nz = 1'b0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.mem_data_out = '0;
        bus.mem_data_out_ready = 1'b1;
        bus.mem_busy = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // UART_OUT byte store: one-cycle write pulse, response two cycles after accept.
        issue(1'b1, 2'b00, 1'b1, 32'hFFFF_FFFE, 32'h0000_0041, 1'b1, 32'h0, 1'b0, 2);
        chk("uart_st_wt", {30'b0, bus.mem_write_type}, 32'd1);
        chk("uart_st_data", {24'b0, bus.mem_data_in[7:0]}, 32'h41);
        chk("uart_st_addr", bus.mem_address, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        chk("uart_st_wt_clear", {30'b0, bus.mem_write_type}, 32'd0);

        // UART_IN unsigned byte load.
        bus.mem_data_out = 32'h0000_005A;
        issue(1'b0, 2'b00, 1'b1, 32'hFFFF_FFFD, 32'h0, 1'b1, 32'h0000_005A, 1'b0, 2);
        chk("uart_ld_rt", {29'b0, bus.mem_read_type}, 32'd1);
        @(posedge clk); #1;
        chk("uart_ld_rt_clear", {29'b0, bus.mem_read_type}, 32'd0);

        // Signed byte load from RAM with a ten-cycle busy stall.
        bus.mem_busy = 1'b1;
        bus.mem_data_out_ready = 1'b0;
        bus.mem_data_out = 32'h8012_3456;
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0, 13);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.mem_read_type != 3'b101) bad++;
            @(posedge clk); #1;
        end
        bus.mem_busy = 1'b0;
        bus.mem_data_out_ready = 1'b1;
        if (bus.mem_read_type != 3'b101) bad++;
        @(posedge clk); #1;
        if (bus.mem_read_type != 3'b101) bad++;
        chk("busy_rt_hold_bad_cycles", bad, 32'd0);
        @(posedge clk); #1;
        chk("busy_rt_resp", {29'b0, bus.mem_read_type}, 32'd0);

        // Illegal accesses answer one cycle after accept with no bus activity.
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h1111_2222, 1'b1, 32'h0, 1'b1, 1);
        chk("mis_word_wt", {30'b0, bus.mem_write_type}, 32'd0);
        chk("mis_word_addr", bus.mem_address, 32'd0);
        issue(1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h3333_4444, 1'b1, 32'h0, 1'b1, 1);
        chk("io_half_wt", {30'b0, bus.mem_write_type}, 32'd0);
        issue(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFD, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        issue(1'b0, 2'b10, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        issue(1'b0, 2'b11, 1'b1, 32'h0000_0000, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        chk("size11_rt", {29'b0, bus.mem_read_type}, 32'd0);

        // RAM load hits: lane select and extension.
        foreach (vecs[i]) begin
            bus.mem_data_out = vecs[i].data;
            issue(1'b0, vecs[i].sz, vecs[i].uns, vecs[i].addr, 32'h0, 1'b1, vecs[i].exp, 1'b0, 3);
            chk("ram_ld_rt", {29'b0, bus.mem_read_type}, {29'b0, vecs[i].rt});
            repeat (2) @(posedge clk);
            #1;
        end

        // RAM word store hit: write pulse one cycle after ISSUE.
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0, 3);
        chk("ram_st_issue_wt", {30'b0, bus.mem_write_type}, 32'd0);
        @(posedge clk); #1;
        chk("ram_st_wt", {30'b0, bus.mem_write_type}, 32'd3);
        chk("ram_st_data", bus.mem_data_in, 32'hCAFE_F00D);
        @(posedge clk); #1;
        chk("ram_st_wt_clear", {30'b0, bus.mem_write_type}, 32'd0);

        // Timeout: cache stuck busy, error 16 cycles after accept.
        bus.mem_busy = 1'b1;
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 32'h0, 1'b1, 16);
        repeat (15) @(posedge clk);
        #1;
        chk("tmo_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
        chk("tmo_rt", {29'b0, bus.mem_read_type}, 32'd0);
        bus.mem_busy = 1'b0;

        // Reset while waiting on a RAM store: abandoned, no response.
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 0);
        @(posedge clk); #1;
        bus.mem_busy = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_busy = 1'b0;
        bus.mem_data_out = 32'h0000_0077;
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0000, 32'h0, 1'b1, 32'h0000_0077, 1'b0, 3);

        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("sb_drain", sb.size(), 32'd0);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_request_sequencer.md
Name: mem_request_sequencer

Overview:
Upstream of the RAM/UART/LED I/O block: converts the core's single-outstanding load/store requests into that block's level-held request interface. Holds address, type and data stable across cache busy periods and samples read data on the correct cycle. Pulses write_type for exactly one cycle so UART/LED side effects fire once. Rejects misaligned and wrong-width I/O accesses, and bounds every access with a timeout.

Parameters:
ADDRESS_BITWIDTH, 32, address width
DATA_WIDTH, 32, data width
TOP_ADDRESS, all ones, top of address space
ADDRESS_LEDS, TOP_ADDRESS, LED register
ADDRESS_UART_OUT, TOP_ADDRESS-1, UART transmit byte
ADDRESS_UART_IN, TOP_ADDRESS-2, UART receive byte
TIMEOUT_CYCLES, 4096, max cycles waiting on memory before error

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  high in IDLE only; accept = req_valid && req_ready
req_write  in  1  1 store, 0 load
req_size  in  2  00 byte, 01 half, 10 word (11 illegal)
req_unsigned  in  1  load zero-extends when 1
req_addr  in  ADDRESS_BITWIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse, no backpressure
resp_rdata  out  DATA_WIDTH  load result; 0 for stores/errors
resp_err  out  1  with resp_valid: misaligned, illegal size, I/O width or timeout
mem_address  out  ADDRESS_BITWIDTH  to I/O block address
mem_write_type  out  2  00 none, 01 byte, 10 half, 11 word
mem_read_type  out  3  000 none; [2]=signed; [1:0] as write_type
mem_data_in  out  DATA_WIDTH  store data
mem_data_out  in  DATA_WIDTH  read data (combinational in I/O block)
mem_data_out_ready  in  1  cache read data valid
mem_busy  in  1  cache busy

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_* outputs all 0; timeout counter 0.
- Accept: capture write, size, unsigned, addr, wdata into registers; the core may change inputs afterwards.
- Error check at accept:
  - half with addr[0]=1, word with addr[1:0]!=0, or size 11 → ERR.
  - Access to an I/O address with size!=byte, or an unsigned=0 load from UART_IN/UART_OUT → ERR.
  - ERR → RESP next cycle with resp_err=1; no mem_* activity.
- Type mapping:
  - write_type = size+1.
  - read_type = {!unsigned, size+1}, except a word load always uses 111.
  - I/O load always uses 001.
- States:
  - IDLE.
  - ISSUE: drive mem_address.
    - I/O load: drive read_type for this one cycle, capture mem_data_out, → RESP.
    - I/O store: drive write_type one cycle, → RESP.
    - RAM access: if !mem_busy, assert types, → WAIT_RD or WAIT_WR.
  - WAIT_RD: hold read_type and address; on mem_data_out_ready && !mem_busy, capture mem_data_out → RESP.
  - WAIT_WR: write_type forced 00, address/data held; on !mem_busy → RESP.
  - RESP: resp_valid=1 for exactly one cycle; mem_* cleared to 0; → IDLE.
- Latency:
  - Accept at cycle N. I/O access: resp_valid at N+2.
  - Error: resp_valid at N+1.
  - RAM hit with busy never asserted: resp_valid at N+3.
- Timeout: counter clears on accept and increments in ISSUE/WAIT_*. On reaching TIMEOUT_CYCLES-1: → RESP, resp_err=1, resp_rdata=0, mem_* cleared.
- Back-to-back: next request accepted in the cycle after RESP (IDLE); no request overlap.
- mem_write_type is never nonzero on two consecutive cycles.
- Reset mid-operation: immediate return to IDLE with reset values; an in-flight access is abandoned and no resp_valid is issued.

Decomposition:
- Package mem_seq_pkg:
  - state enum {IDLE, ISSUE, WAIT_RD, WAIT_WR, RESP}
  - size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD)
  - write_type and read_type localparams (WT_NONE/BYTE/HALF/WORD, RT_NONE, RT_SIGNED_BIT)
- Single module. Alignment/I/O legality checks are a combinational function in the package, not a separate sub-module.

Test Plan:
- Store byte 0x41 to 0xFFFFFFFE (UART_OUT) → mem_write_type=01 for exactly 1 cycle, mem_data_in[7:0]=0x41; resp_valid at N+2, resp_err=0.
- Load byte unsigned from 0xFFFFFFFD with mem_data_out=0x0000005A → mem_read_type=001 for 1 cycle; resp_rdata=0x0000005A at N+2.
- Signed byte load from 0x00000003, mem_busy high for 10 cycles then data_out_ready with mem_data_out=0x80xxxxxx:
  - read_type held at 101 throughout.
  - resp_rdata=0xFFFFFF80.
- Word store to 0x00000102 → resp_err=1 at N+1; mem_write_type stays 00. Half store to 0xFFFFFFFF → resp_err=1.
- Word load with mem_busy stuck high, TIMEOUT_CYCLES=16 → resp_valid with resp_err=1 exactly 16 cycles after accept; mem_read_type 000 in the RESP cycle.
- Assert rst_n=0 during WAIT_WR → all outputs at reset values within same cycle; no resp_valid. A new request after release completes normally.
